// File: rtl/extrator_caixa_obstaculo.sv
// Recovers, once per frame, the obstacle rectangle (origin, width, length)
// from the per-pixel draw flag stream seen during scan-out. The renderer
// draws strictly inside coord < pos < coord+size, so the published origin
// sits one below the first drawn pixel and the size spans both borders.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// SINC    | after reset: ignore pixels until the first frame boundary
// ACUMULA | accumulate bounding box and hit count of the current frame
// PUBLICA | one cycle: outputs carry the closed frame, new frame starts
module extrator_caixa_obstaculo #(
  parameter int X_BITS   = 10,
  parameter int Y_BITS   = 9,
  parameter int CNT_BITS = 19
) (
  input  logic                VGA_clk,
  input  logic                reset_n,
  input  logic [X_BITS-1:0]   xCol,
  input  logic [Y_BITS-1:0]   yRow,
  input  logic                ativo,
  input  logic                desenha,
  input  logic                fim_quadro,
  output logic [X_BITS-1:0]   coordenada_x,
  output logic [Y_BITS-1:0]   coordenada_y,
  output logic [X_BITS-1:0]   largura,
  output logic [Y_BITS-1:0]   comprimento,
  output logic [CNT_BITS-1:0] contagem,
  output logic                valido,
  output logic                borda,
  output logic                atualizado
);

  typedef enum logic [1:0] {SINC, ACUMULA, PUBLICA} estado_t;

  localparam logic [X_BITS-1:0]   UM_X   = X_BITS'(1);
  localparam logic [Y_BITS-1:0]   UM_Y   = Y_BITS'(1);
  localparam logic [CNT_BITS-1:0] UM_CNT = CNT_BITS'(1);

  estado_t estado_q, estado_d;

  logic [X_BITS-1:0]   min_x_q, min_x_d, max_x_q, max_x_d;
  logic [Y_BITS-1:0]   min_y_q, min_y_d, max_y_q, max_y_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                achou_q, achou_d;

  logic [X_BITS-1:0]   base_min_x, base_max_x;
  logic [Y_BITS-1:0]   base_min_y, base_max_y;
  logic [CNT_BITS-1:0] base_cnt;
  logic                base_achou;

  logic hit, limpa, acumula, publica;

  logic [X_BITS-1:0] org_x, larg_x;
  logic [Y_BITS-1:0] org_y, comp_y;

  assign hit = ativo && desenha;

  // Next state plus which accumulator action the current state allows
  always_comb begin
    estado_d = estado_q;
    limpa    = 1'b0;
    acumula  = 1'b0;
    publica  = 1'b0;
    case (estado_q)
      SINC: begin
        if (fim_quadro) begin
          estado_d = ACUMULA;
          limpa    = 1'b1;
        end
      end
      ACUMULA: begin
        acumula = hit;
        if (fim_quadro) begin
          estado_d = PUBLICA;
          publica  = 1'b1;
        end
      end
      PUBLICA: begin
        // fim_quadro here is deliberately ignored: no empty-frame publish
        estado_d = ACUMULA;
        limpa    = 1'b1;
        acumula  = hit;
      end
      default: estado_d = SINC;
    endcase
  end

  // Accumulator update: optional clear, then fold in the current hit
  always_comb begin
    base_min_x = limpa ? '1 : min_x_q;
    base_max_x = limpa ? '0 : max_x_q;
    base_min_y = limpa ? '1 : min_y_q;
    base_max_y = limpa ? '0 : max_y_q;
    base_cnt   = limpa ? '0 : cnt_q;
    base_achou = limpa ? 1'b0 : achou_q;

    min_x_d = base_min_x;
    max_x_d = base_max_x;
    min_y_d = base_min_y;
    max_y_d = base_max_y;
    cnt_d   = base_cnt;
    achou_d = base_achou;

    if (acumula) begin
      if (xCol < base_min_x) min_x_d = xCol;
      if (xCol > base_max_x) max_x_d = xCol;
      if (yRow < base_min_y) min_y_d = yRow;
      if (yRow > base_max_y) max_y_d = yRow;
      if (base_cnt != '1)    cnt_d   = base_cnt + UM_CNT;
      achou_d = 1'b1;
    end
  end

  // Rectangle recovered from the closing frame, including a hit on fim_quadro
  always_comb begin
    org_x  = (min_x_d == '0) ? '0 : (min_x_d - UM_X);
    larg_x = max_x_d - org_x + UM_X;
    org_y  = (min_y_d == '0) ? '0 : (min_y_d - UM_Y);
    comp_y = max_y_d - org_y + UM_Y;
  end

  // State and accumulator registers
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= SINC;
      min_x_q  <= '1;
      max_x_q  <= '0;
      min_y_q  <= '1;
      max_y_q  <= '0;
      cnt_q    <= '0;
      achou_q  <= 1'b0;
    end else begin
      estado_q <= estado_d;
      min_x_q  <= min_x_d;
      max_x_q  <= max_x_d;
      min_y_q  <= min_y_d;
      max_y_q  <= max_y_d;
      cnt_q    <= cnt_d;
      achou_q  <= achou_d;
    end
  end

  // Output registers: loaded on the frame-closing edge, so they are valid
  // during the PUBLICA cycle together with the atualizado pulse
  always_ff @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      coordenada_x <= '0;
      coordenada_y <= '0;
      largura      <= '0;
      comprimento  <= '0;
      contagem     <= '0;
      valido       <= 1'b0;
      borda        <= 1'b0;
      atualizado   <= 1'b0;
    end else begin
      atualizado <= publica;
      if (publica) begin
        valido <= achou_d;
        if (achou_d) begin
          coordenada_x <= org_x;
          coordenada_y <= org_y;
          largura      <= larg_x;
          comprimento  <= comp_y;
          contagem     <= cnt_d;
          borda        <= (min_x_d == '0) || (min_y_d == '0);
        end else begin
          coordenada_x <= '0;
          coordenada_y <= '0;
          largura      <= '0;
          comprimento  <= '0;
          contagem     <= '0;
          borda        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_extrator_caixa_obstaculo.sv
// Directed bench for extrator_caixa_obstaculo: a hit-list model recomputes
// the published rectangle each frame and is compared on every cycle; fixed
// literal expectations pin the model on the key frames.
module tb_extrator_caixa_obstaculo;
  localparam int XB = 10;
  localparam int YB = 9;
  localparam int CB = 19;

  logic          VGA_clk = 1'b0;
  logic          reset_n = 1'b1;
  logic [XB-1:0] xCol = '0;
  logic [YB-1:0] yRow = '0;
  logic          ativo = 1'b0;
  logic          desenha = 1'b0;
  logic          fim_quadro = 1'b0;
  logic [XB-1:0] coordenada_x, largura;
  logic [YB-1:0] coordenada_y, comprimento;
  logic [CB-1:0] contagem;
  logic          valido, borda, atualizado;

  extrator_caixa_obstaculo #(.X_BITS(XB), .Y_BITS(YB), .CNT_BITS(CB)) dut (
    .VGA_clk(VGA_clk), .reset_n(reset_n), .xCol(xCol), .yRow(yRow),
    .ativo(ativo), .desenha(desenha), .fim_quadro(fim_quadro),
    .coordenada_x(coordenada_x), .coordenada_y(coordenada_y),
    .largura(largura), .comprimento(comprimento), .contagem(contagem),
    .valido(valido), .borda(borda), .atualizado(atualizado)
  );

  always #5 VGA_clk = ~VGA_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", nome, act, exp, $time);
    end
  endtask

  // ---------------- model: hits of the open frame, published rectangle
  int unsigned hx[$];
  int unsigned hy[$];
  bit          armado = 0;
  bit          janela_pub = 0;
  logic [31:0] e_cx = 0, e_cy = 0, e_lg = 0, e_cp = 0, e_ct = 0;
  bit          e_val = 0, e_borda = 0, e_atu = 0;

  function automatic void publicar();
    int unsigned mnx, mxx, mny, mxy, cx, cy;
    if (hx.size() == 0) begin
      e_cx = 0; e_cy = 0; e_lg = 0; e_cp = 0; e_ct = 0; e_val = 0; e_borda = 0;
      return;
    end
    mnx = hx[0]; mxx = hx[0]; mny = hy[0]; mxy = hy[0];
    foreach (hx[i]) begin
      if (hx[i] < mnx) mnx = hx[i];
      if (hx[i] > mxx) mxx = hx[i];
      if (hy[i] < mny) mny = hy[i];
      if (hy[i] > mxy) mxy = hy[i];
    end
    cx = (mnx == 0) ? 0 : mnx - 1;
    cy = (mny == 0) ? 0 : mny - 1;
    e_cx = cx;
    e_cy = cy;
    e_lg = (mxx - cx + 1) % (1 << XB);
    e_cp = (mxy - cy + 1) % (1 << YB);
    e_ct = (hx.size() > (1 << CB) - 1) ? (1 << CB) - 1 : hx.size();
    e_val = 1;
    e_borda = (mnx == 0) || (mny == 0);
  endfunction

  always @(posedge VGA_clk or negedge reset_n) begin
    if (!reset_n) begin
      armado = 0; janela_pub = 0; hx.delete(); hy.delete();
      e_cx = 0; e_cy = 0; e_lg = 0; e_cp = 0; e_ct = 0;
      e_val = 0; e_borda = 0; e_atu = 0;
    end else begin
      e_atu = 0;
      if (!armado) begin
        if (fim_quadro) begin
          armado = 1; hx.delete(); hy.delete();
        end
      end else if (janela_pub) begin
        janela_pub = 0; hx.delete(); hy.delete();
        if (ativo && desenha) begin hx.push_back(xCol); hy.push_back(yRow); end
      end else begin
        if (ativo && desenha) begin hx.push_back(xCol); hy.push_back(yRow); end
        if (fim_quadro) begin
          publicar(); e_atu = 1; janela_pub = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge VGA_clk) begin
    chk("m_coordenada_x", 32'(coordenada_x), e_cx);
    chk("m_coordenada_y", 32'(coordenada_y), e_cy);
    chk("m_largura", 32'(largura), e_lg);
    chk("m_comprimento", 32'(comprimento), e_cp);
    chk("m_contagem", 32'(contagem), e_ct);
    chk("m_valido", 32'(valido), 32'(e_val));
    chk("m_borda", 32'(borda), 32'(e_borda));
    chk("m_atualizado", 32'(atualizado), 32'(e_atu));
  end

  // ---------------- stimulus
  task automatic ciclo(input bit a, input bit d, input int x, input int y, input bit f);
    @(posedge VGA_clk);
    #1;
    ativo = a; desenha = d; xCol = XB'(x); yRow = YB'(y); fim_quadro = f;
  endtask

  function automatic bit desenha_em(input int modo, input int x, input int y);
    case (modo)
      1: return (x >= 101 && x <= 119 && y >= 51 && y <= 79);
      2: return (x == 0 && y == 0) || (x == 5 && y == 3);
      3: return (x >= 3 && x <= 6 && y >= 2 && y <= 4);
      4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Raster of w x h visible pixels, each line followed by blanking with desenha=1
  task automatic quadro(input int w, input int h, input int modo, input bit vis);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) ciclo(vis, desenha_em(modo, x, y), x, y, 1'b0);
      for (int b = 0; b < 4; b++) ciclo(1'b0, 1'b1, w + b, y, 1'b0);
    end
  endtask

  task automatic fecha();
    ciclo(1'b0, 1'b0, 0, 0, 1'b1);
    ciclo(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge VGA_clk);
  endtask

  task automatic pins(input string t, input int cx, input int lg, input int cy, input int cp,
                      input int ct, input bit val, input bit bor, input bit atu);
    chk({t, "_coordenada_x"}, 32'(coordenada_x), cx);
    chk({t, "_largura"}, 32'(largura), lg);
    chk({t, "_coordenada_y"}, 32'(coordenada_y), cy);
    chk({t, "_comprimento"}, 32'(comprimento), cp);
    chk({t, "_contagem"}, 32'(contagem), ct);
    chk({t, "_valido"}, 32'(valido), 32'(val));
    chk({t, "_borda"}, 32'(borda), 32'(bor));
    chk({t, "_atualizado"}, 32'(atualizado), 32'(atu));
  endtask

  initial begin
    #1 reset_n = 1'b0;
    repeat (3) @(posedge VGA_clk);
    #1 reset_n = 1'b1;
    @(negedge VGA_clk);
    pins("reset", 0, 0, 0, 0, 0, 0, 0, 0);

    // hits while still in SINC are discarded; first boundary does not publish
    quadro(16, 8, 4, 1'b1);
    fecha();
    chk("sinc_no_publish", 32'(atualizado), 0);
    quadro(16, 8, 0, 1'b1);
    fecha();
    pins("empty", 0, 0, 0, 0, 0, 0, 0, 1);

    quadro(128, 96, 1, 1'b1);
    fecha();
    pins("box", 100, 20, 50, 30, 551, 1, 0, 1);
    ciclo(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge VGA_clk);
    pins("box_hold", 100, 20, 50, 30, 551, 1, 0, 0);

    quadro(16, 8, 2, 1'b1);
    fecha();
    pins("corner", 0, 6, 0, 4, 2, 1, 1, 1);

    // single hit on fim_quadro; hit plus a second fim_quadro in the publish cycle
    quadro(16, 8, 0, 1'b1);
    ciclo(1'b1, 1'b1, 10, 10, 1'b1);
    ciclo(1'b1, 1'b1, 3, 4, 1'b1);
    @(negedge VGA_clk);
    pins("fim_hit", 9, 2, 9, 2, 1, 1, 0, 1);
    ciclo(1'b0, 1'b0, 0, 0, 1'b0);
    @(negedge VGA_clk);
    chk("double_fim_one_pulse", 32'(atualizado), 0);
    quadro(16, 8, 0, 1'b1);
    fecha();
    pins("pub_load", 2, 2, 3, 2, 1, 1, 0, 1);

    // asynchronous reset mid-frame
    quadro(16, 4, 3, 1'b1);
    @(posedge VGA_clk);
    #2 reset_n = 1'b0;
    #1 pins("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge VGA_clk);
    #1 reset_n = 1'b1;
    quadro(16, 8, 3, 1'b1);
    fecha();
    pins("rst_sinc", 0, 0, 0, 0, 0, 0, 0, 0);
    quadro(16, 8, 3, 1'b1);
    fecha();
    pins("rst_recover", 2, 5, 1, 4, 12, 1, 0, 1);

    // desenha everywhere with ativo low
    quadro(16, 8, 4, 1'b0);
    fecha();
    pins("inactive", 0, 0, 0, 0, 0, 0, 0, 1);

    repeat (2) @(negedge VGA_clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
